// File: rtl/exec_seq_pkg.sv
// Shared state encoding and decode helpers for the P-D execution-phase sequencer.
package exec_seq_pkg;

   typedef logic [3:0] state_t;
   typedef logic       sub_t;

   localparam state_t ST_IDLE = 4'd0;
   localparam state_t ST_P1   = 4'd1;
   localparam state_t ST_P4   = 4'd2;
   localparam state_t ST_PP   = 4'd3;
   localparam state_t ST_WA   = 4'd4;
   localparam state_t ST_WP   = 4'd5;
   localparam state_t ST_WE   = 4'd6;
   localparam state_t ST_WR   = 4'd7;
   localparam state_t ST_WM   = 4'd8;
   localparam state_t ST_WW   = 4'd9;
   localparam state_t ST_WX   = 4'd10;
   localparam state_t ST_WZ   = 4'd11;
   localparam state_t ST_WAND = 4'd12;
   localparam state_t ST_KC   = 4'd13;

   localparam sub_t SUB_S1 = 1'b0;
   localparam sub_t SUB_S2 = 1'b1;

   typedef struct packed {
      state_t nxt;
      logic   multi;
      logic   none;
   } pick_t;

   function automatic logic is_mem_state(input state_t st);
      case (st)
         ST_P1, ST_P4, ST_WR, ST_WM, ST_WW: is_mem_state = 1'b1;
         default:                           is_mem_state = 1'b0;
      endcase
   endfunction

   // req[9] is the merged cycle-end request; req[8:0] are ewa..ew__ in falling priority
   function automatic pick_t pick_next(input logic [9:0] req);
      pick_t r;
      r.multi = |(req & (req - 10'd1));
      r.none  = ~|req;
      if (req[9])      r.nxt = ST_KC;
      else if (req[8]) r.nxt = ST_WA;
      else if (req[7]) r.nxt = ST_WP;
      else if (req[6]) r.nxt = ST_WE;
      else if (req[5]) r.nxt = ST_WR;
      else if (req[4]) r.nxt = ST_WM;
      else if (req[3]) r.nxt = ST_WW;
      else if (req[2]) r.nxt = ST_WX;
      else if (req[1]) r.nxt = ST_WZ;
      else if (req[0]) r.nxt = ST_WAND;
      else             r.nxt = ST_KC;
      return r;
   endfunction

   // One-hot flag vector ordered p1,p4,pp,wa,wp,we,wr,wm,ww,wx,wz,w__ from the MSB
   function automatic logic [11:0] state_flags(input state_t st);
      if ((st >= ST_P1) && (st <= ST_WAND)) begin
         state_flags = 12'h800 >> (st - ST_P1);
      end else begin
         state_flags = 12'h000;
      end
   endfunction

endpackage

// File: rtl/exec_seq_tmo.sv
// Memory-answer timeout counter: counts wait cycles, flags expiry on the last allowed one.
module exec_seq_tmo #(
   parameter int TMO_CYCLES = 64,
   parameter int TMO_W      = 10
) (
   input  logic clk_sys,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [TMO_W-1:0] cnt_r;

   // wait-cycle counter
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         cnt_r <= {TMO_W{1'b0}};
      end else if (clr) begin
         cnt_r <= {TMO_W{1'b0}};
      end else if (en) begin
         cnt_r <= cnt_r + TMO_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expired = en && (cnt_r == TMO_W'(TMO_CYCLES - 1));

endmodule

// File: rtl/exec_seq.sv
// Execution-phase sequencer: owns the one-hot CPU cycle state, STROB1/STROB2 substates,
// the memory handshake with its timeout alarm, and the sticky sequencing-error flag.
module exec_seq
   import exec_seq_pkg::*;
#(
   parameter int TMO_CYCLES = 64,
   parameter int TMO_W      = 10
) (
   input  logic clk_sys,
   input  logic rst,
   input  logic start,
   input  logic stop,
   input  logic c0,
   input  logic nef,
   input  logic ewa,
   input  logic ewp,
   input  logic ewe,
   input  logic ewr,
   input  logic ewm,
   input  logic eww,
   input  logic ewx,
   input  logic ewz,
   input  logic ew__,
   input  logic ekc_1,
   input  logic ekc_2,
   input  logic mem_ok,
   output logic p1,
   output logic p4,
   output logic pp,
   output logic wa,
   output logic wp,
   output logic we,
   output logic wr,
   output logic wm,
   output logic ww,
   output logic wx,
   output logic wz,
   output logic w__,
   output logic kc,
   output logic strob1,
   output logic strob2,
   output logic w_ir,
   output logic mem_req,
   output logic alarm,
   output logic seq_err,
   output logic busy
);

   state_t      state_r, state_nx_s;
   sub_t        sub_r, sub_nx_s;
   logic        alarm_r, alarm_nx_s;
   logic        seq_err_r, seq_err_nx_s;
   logic [11:0] flags_r;
   logic        kc_r, strob1_r, strob2_r, w_ir_r, mem_req_r, busy_r;
   logic        mem_wait_s, tmo_exp_s;
   logic [9:0]  req_s;
   pick_t       pick_s;

   assign req_s      = {ekc_1 | ekc_2, ewa, ewp, ewe, ewr, ewm, eww, ewx, ewz, ew__};
   assign pick_s     = pick_next(req_s);
   assign mem_wait_s = is_mem_state(state_r) && (sub_r == SUB_S1) && !mem_ok;

   exec_seq_tmo #(.TMO_CYCLES(TMO_CYCLES), .TMO_W(TMO_W)) u_tmo (
      .clk_sys (clk_sys),
      .rst     (rst),
      .clr     (!mem_wait_s),
      .en      (mem_wait_s),
      .expired (tmo_exp_s)
   );

   // next state, substate and sticky flags
   always_comb begin
      state_nx_s   = state_r;
      sub_nx_s     = sub_r;
      alarm_nx_s   = alarm_r;
      seq_err_nx_s = seq_err_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nx_s   = ST_P1;
               sub_nx_s     = SUB_S1;
               alarm_nx_s   = 1'b0;
               seq_err_nx_s = 1'b0;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_KC: begin
            sub_nx_s = SUB_S1;
            if (stop) state_nx_s = ST_IDLE;
            else      state_nx_s = ST_P1;
         end
         ST_P1, ST_P4, ST_PP, ST_WA, ST_WP, ST_WE, ST_WR, ST_WM, ST_WW, ST_WX, ST_WZ, ST_WAND: begin
            if (sub_r == SUB_S1) begin
               if (!is_mem_state(state_r) || mem_ok) begin
                  sub_nx_s = SUB_S2;
               end else if (tmo_exp_s) begin
                  alarm_nx_s = 1'b1;
                  state_nx_s = ST_KC;
               end else begin
                  sub_nx_s = SUB_S1;
               end
            end else begin
               sub_nx_s = SUB_S1;
               if (state_r == ST_P1) begin
                  state_nx_s = c0 ? ST_P4 : ST_PP;
               end else if (state_r == ST_P4) begin
                  state_nx_s = ST_PP;
               end else if ((state_r == ST_PP) && nef) begin
                  state_nx_s = ST_KC;
               end else begin
                  state_nx_s   = pick_s.nxt;
                  seq_err_nx_s = seq_err_r | pick_s.multi | pick_s.none;
               end
            end
         end
         default: begin
            // corrupted encoding: park safely and report it
            state_nx_s   = ST_IDLE;
            sub_nx_s     = SUB_S1;
            seq_err_nx_s = 1'b1;
         end
      endcase
   end

   // state registers and outputs registered from the next-state decode
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         sub_r     <= SUB_S1;
         alarm_r   <= 1'b0;
         seq_err_r <= 1'b0;
         flags_r   <= 12'h000;
         kc_r      <= 1'b0;
         strob1_r  <= 1'b0;
         strob2_r  <= 1'b0;
         w_ir_r    <= 1'b0;
         mem_req_r <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_nx_s;
         sub_r     <= sub_nx_s;
         alarm_r   <= alarm_nx_s;
         seq_err_r <= seq_err_nx_s;
         flags_r   <= state_flags(state_nx_s);
         kc_r      <= (state_nx_s == ST_KC);
         strob1_r  <= (|state_flags(state_nx_s)) && (sub_nx_s == SUB_S1);
         strob2_r  <= (|state_flags(state_nx_s)) && (sub_nx_s == SUB_S2);
         w_ir_r    <= (state_nx_s == ST_P1) && (sub_nx_s == SUB_S2);
         mem_req_r <= is_mem_state(state_nx_s) && (sub_nx_s == SUB_S1);
         busy_r    <= (state_nx_s != ST_IDLE);
      end
   end

   assign {p1, p4, pp, wa, wp, we, wr, wm, ww, wx, wz, w__} = flags_r;
   assign kc      = kc_r;
   assign strob1  = strob1_r;
   assign strob2  = strob2_r;
   assign w_ir    = w_ir_r;
   assign mem_req = mem_req_r;
   assign alarm   = alarm_r;
   assign seq_err = seq_err_r;
   assign busy    = busy_r;

endmodule
